parking_occupancy_fsm: RTL and testbench

Sensor-side decoder for the two-beam parking-lot entrance: it samples the beam sensors `a` (outer) and `b` (inner) and recognises complete entry and exit sequences. For each completed crossing it issues a one-cycle `inc` or `dec` pulse and maintains the saturating occupancy `count`. It is the DUT the stimulus generator drives. The scoreboard checks `inc`/`dec`/`count` against its expected values.

---
 rtl/parking_occupancy_fsm.sv | 177 +++++++++++++++++
 tb/tb_parking_occupancy_fsm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_fsm.sv
// Two-beam parking entrance decoder: synchronises the outer/inner beam sensors,
// recognises complete entry/exit crossings and keeps a saturating occupancy count.
module parking_occupancy_fsm #(
  parameter int COUNT_W   = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic               inc,
  output logic               dec,
  output logic               err,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  typedef enum logic [2:0] {
    IDLE,
    ENT1,
    ENT2,
    ENT3,
    EXT1,
    EXT2,
    EXT3,
    ABORT
  } state_e;

  localparam logic [COUNT_W-1:0] MaxCount = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] OneCount = COUNT_W'(1);

  if (MAX_COUNT > (2 ** COUNT_W) - 1) begin : g_bad_max
    $error("MAX_COUNT does not fit in COUNT_W bits");
  end

  logic               aMeta_q, aSync_q;
  logic               bMeta_q, bSync_q;
  logic [1:0]         ab;
  state_e             state_q, state_d;
  logic               entryDone, exitDone;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Two-flop synchroniser for the asynchronous beam inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aMeta_q <= 1'b0;
      aSync_q <= 1'b0;
      bMeta_q <= 1'b0;
      bSync_q <= 1'b0;
    end else begin
      aMeta_q <= a;
      aSync_q <= aMeta_q;
      bMeta_q <= b;
      bSync_q <= bMeta_q;
    end
  end

  assign ab = {aSync_q, bSync_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Exit states mirror the entry states with the roles of a and b swapped.
  always_comb begin
    state_d   = state_q;
    entryDone = 1'b0;
    exitDone  = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   state_d = ENT1;
          2'b01:   state_d = EXT1;
          2'b11:   state_d = ABORT;
          default: state_d = IDLE;
        endcase
      end
      ENT1: begin
        case (ab)
          2'b11:   state_d = ENT2;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = ABORT;
          default: state_d = ENT1;
        endcase
      end
      ENT2: begin
        case (ab)
          2'b01:   state_d = ENT3;
          2'b10:   state_d = ENT1;
          2'b00:   state_d = ABORT;
          default: state_d = ENT2;
        endcase
      end
      ENT3: begin
        case (ab)
          2'b11:   state_d = ENT2;
          2'b10:   state_d = ABORT;
          2'b00: begin
            state_d   = IDLE;
            entryDone = 1'b1;
          end
          default: state_d = ENT3;
        endcase
      end
      EXT1: begin
        case (ab)
          2'b11:   state_d = EXT2;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = ABORT;
          default: state_d = EXT1;
        endcase
      end
      EXT2: begin
        case (ab)
          2'b10:   state_d = EXT3;
          2'b01:   state_d = EXT1;
          2'b00:   state_d = ABORT;
          default: state_d = EXT2;
        endcase
      end
      EXT3: begin
        case (ab)
          2'b11:   state_d = EXT2;
          2'b01:   state_d = ABORT;
          2'b00: begin
            state_d  = IDLE;
            exitDone = 1'b1;
          end
          default: state_d = EXT3;
        endcase
      end
      ABORT: begin
        if (ab == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating occupancy update; a blocked step is flagged on err instead of wrapping.
  always_comb begin
    inc_d   = entryDone;
    dec_d   = exitDone;
    err_d   = 1'b0;
    count_d = count_q;
    if (entryDone) begin
      if (count_q < MaxCount) count_d = count_q + OneCount;
      else                    err_d   = 1'b1;
    end else if (exitDone) begin
      if (count_q != '0) count_d = count_q - OneCount;
      else               err_d   = 1'b1;
    end
  end

  assign inc   = inc_q;
  assign dec   = dec_q;
  assign err   = err_q;
  assign count = count_q;
  assign full  = (count_q == MaxCount);
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_parking_occupancy_fsm.sv
// Directed bench for parking_occupancy_fsm: drives beam sequences and checks
// pulses, occupancy, saturation, latency and asynchronous reset behaviour.
module tb_parking_occupancy_fsm;

  logic       clk;
  logic       reset;
  logic       a;
  logic       b;
  logic       inc;
  logic       dec;
  logic       err;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int errors;
  int checks;
  int incCnt;
  int decCnt;
  int errCnt;
  int incErrCnt;
  int decErrCnt;
  int bothCnt;

  parking_occupancy_fsm #(.COUNT_W(4), .MAX_COUNT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .inc  (inc),
    .dec  (dec),
    .err  (err),
    .count(count),
    .full (full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled away from the rising edge.
  always @(negedge clk) begin
    if (inc)        incCnt++;
    if (dec)        decCnt++;
    if (err)        errCnt++;
    if (inc && err) incErrCnt++;
    if (dec && err) decErrCnt++;
    if (inc && dec) bothCnt++;
  end

  task automatic clearTallies();
    incCnt = 0; decCnt = 0; errCnt = 0;
    incErrCnt = 0; decErrCnt = 0; bothCnt = 0;
  endtask

  task automatic driveAb(input logic [1:0] v, input int n);
    a = v[1];
    b = v[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    a = 1'b0; b = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic doEntry();
    driveAb(2'b10, 4); driveAb(2'b11, 4); driveAb(2'b01, 4); driveAb(2'b00, 4);
  endtask

  task automatic doExit();
    driveAb(2'b01, 4); driveAb(2'b11, 4); driveAb(2'b10, 4); driveAb(2'b00, 4);
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 5; i++) doEntry();
    checks++;
    if (count !== 4'd5) begin
      errors++; $display("[TB] FAIL reset_precount: count=%0d expected 5", count);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({count, empty, full, inc, dec, err} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_async: count=%0d empty=%b full=%b inc=%b dec=%b err=%b expected 0 1 0 0 0 0",
               count, empty, full, inc, dec, err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clearTallies();
    repeat (6) @(negedge clk);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || incCnt != 0 || decCnt != 0 || errCnt != 0) begin
      errors++;
      $display("[TB] FAIL reset_release: count=%0d empty=%b inc#=%0d dec#=%0d err#=%0d expected 0 1 0 0 0",
               count, empty, incCnt, decCnt, errCnt);
    end
  endtask

  task automatic test_entry();
    clearTallies();
    driveAb(2'b00, 4); driveAb(2'b10, 4); driveAb(2'b11, 4); driveAb(2'b01, 4);
    a = 1'b0; b = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      checks++;
      if (inc !== (e == 3)) begin
        errors++; $display("[TB] FAIL entry_latency_%0d: inc=%b expected %b", e, inc, (e == 3));
      end
    end
    checks++;
    if (count !== 4'd1 || empty !== 1'b0 || incCnt != 1 || decCnt != 0 || errCnt != 0) begin
      errors++;
      $display("[TB] FAIL entry_result: count=%0d empty=%b inc#=%0d dec#=%0d err#=%0d expected 1 0 1 0 0",
               count, empty, incCnt, decCnt, errCnt);
    end
  endtask

  task automatic test_exit();
    clearTallies();
    driveAb(2'b00, 4);
    doExit();
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || decCnt != 1 || incCnt != 0 || errCnt != 0) begin
      errors++;
      $display("[TB] FAIL exit_result: count=%0d empty=%b dec#=%0d inc#=%0d err#=%0d expected 0 1 1 0 0",
               count, empty, decCnt, incCnt, errCnt);
    end
  endtask

  task automatic test_backout();
    logic [1:0] seqs [3][5];
    int         lens [3];
    seqs[0] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b00}; lens[0] = 5;
    seqs[1] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00}; lens[1] = 5;
    seqs[2] = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b00}; lens[2] = 4;
    doReset();
    for (int i = 0; i < 3; i++) doEntry();
    for (int s = 0; s < 3; s++) begin
      clearTallies();
      for (int i = 0; i < lens[s]; i++) driveAb(seqs[s][i], 4);
      repeat (2) @(negedge clk);
      checks++;
      if (count !== 4'd3 || incCnt != 0 || decCnt != 0 || errCnt != 0) begin
        errors++;
        $display("[TB] FAIL backout_%0d: count=%0d inc#=%0d dec#=%0d err#=%0d expected 3 0 0 0",
                 s, count, incCnt, decCnt, errCnt);
      end
    end
    clearTallies();
    doEntry();
    checks++;
    if (count !== 4'd4 || incCnt != 1) begin
      errors++; $display("[TB] FAIL backout_recover: count=%0d inc#=%0d expected 4 1", count, incCnt);
    end
  endtask

  task automatic test_saturation();
    doReset();
    clearTallies();
    for (int i = 0; i < 15; i++) doEntry();
    checks++;
    if (count !== 4'd15 || full !== 1'b1 || incCnt != 15 || errCnt != 0) begin
      errors++;
      $display("[TB] FAIL sat_fill: count=%0d full=%b inc#=%0d err#=%0d expected 15 1 15 0",
               count, full, incCnt, errCnt);
    end
    clearTallies();
    doEntry();
    checks++;
    if (count !== 4'd15 || incCnt != 1 || errCnt != 1 || incErrCnt != 1) begin
      errors++;
      $display("[TB] FAIL sat_over: count=%0d inc#=%0d err#=%0d inc&err#=%0d expected 15 1 1 1",
               count, incCnt, errCnt, incErrCnt);
    end
    clearTallies();
    for (int i = 0; i < 15; i++) doExit();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || decCnt != 15 || errCnt != 0) begin
      errors++;
      $display("[TB] FAIL sat_drain: count=%0d empty=%b full=%b dec#=%0d err#=%0d expected 0 1 0 15 0",
               count, empty, full, decCnt, errCnt);
    end
    clearTallies();
    doExit();
    checks++;
    if (count !== 4'd0 || decCnt != 1 || errCnt != 1 || decErrCnt != 1 || incCnt != 0) begin
      errors++;
      $display("[TB] FAIL sat_under: count=%0d dec#=%0d err#=%0d dec&err#=%0d inc#=%0d expected 0 1 1 1 0",
               count, decCnt, errCnt, decErrCnt, incCnt);
    end
  endtask

  task automatic test_reset_mid_entry();
    doReset();
    doEntry();
    doEntry();
    checks++;
    if (count !== 4'd2) begin
      errors++; $display("[TB] FAIL midreset_pre: count=%0d expected 2", count);
    end
    driveAb(2'b10, 4);
    driveAb(2'b11, 4);
    reset = 1'b0;
    a = 1'b0; b = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_clear: count=%0d empty=%b expected 0 1", count, empty);
    end
    clearTallies();
    reset = 1'b1;
    driveAb(2'b01, 4);
    driveAb(2'b00, 4);
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 4'd0 || incCnt != 0 || decCnt != 0 || errCnt != 0) begin
      errors++;
      $display("[TB] FAIL midreset_resume: count=%0d inc#=%0d dec#=%0d err#=%0d expected 0 0 0 0",
               count, incCnt, decCnt, errCnt);
    end
    clearTallies();
    doEntry();
    checks++;
    if (count !== 4'd1 || incCnt != 1) begin
      errors++; $display("[TB] FAIL midreset_after: count=%0d inc#=%0d expected 1 1", count, incCnt);
    end
  endtask

  task automatic test_back_to_back();
    clearTallies();
    doEntry();
    doEntry();
    doExit();
    doEntry();
    checks++;
    if (count !== 4'd3 || incCnt != 3 || decCnt != 1 || bothCnt != 0) begin
      errors++;
      $display("[TB] FAIL back_to_back: count=%0d inc#=%0d dec#=%0d both#=%0d expected 3 3 1 0",
               count, incCnt, decCnt, bothCnt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clearTallies();
    a = 1'b0;
    b = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, empty, full, inc, dec, err} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL initial_reset: count=%0d empty=%b full=%b inc=%b dec=%b err=%b expected 0 1 0 0 0 0",
               count, empty, full, inc, dec, err);
    end
    test_reset();
    test_entry();
    test_exit();
    test_backout();
    test_saturation();
    test_reset_mid_entry();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
